// File: rtl/cla_pkg.sv
// Shared encodings and constants for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    localparam logic OP_ADD  = 1'b0;
    localparam logic OP_SUB  = 1'b1;
    localparam int   CLA_GRP = 4;

    // Subtraction is A + ~B + 1, so the op bit doubles as the initial carry.
    function automatic logic carry_in(input logic op);
        return (op == OP_SUB);
    endfunction

endpackage

// File: rtl/cla_grp4.sv
// 4-bit carry-lookahead group: local sums plus group generate/propagate for the next level.
module cla_grp4
    import cla_pkg::*;
(
    input  logic [CLA_GRP-1:0] a,
    input  logic [CLA_GRP-1:0] b,
    input  logic               cin,
    output logic [CLA_GRP-1:0] sum,
    output logic               g,
    output logic               p
);

    logic [CLA_GRP-1:0] gi;
    logic [CLA_GRP-1:0] pi;
    logic [CLA_GRP-1:0] c;

    assign gi = a & b;
    assign pi = a ^ b;

    assign c[0] = cin;
    assign c[1] = gi[0] | (pi[0] & cin);
    assign c[2] = gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin);
    assign c[3] = gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0])
                | (pi[2] & pi[1] & pi[0] & cin);

    assign sum = pi ^ c;

    // G and P never depend on cin, so the segment lookahead above this group stays flat.
    assign g = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1])
             | (pi[3] & pi[2] & pi[1] & gi[0]);
    assign p = &pi;

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead add/sub: each stage resolves one WIDTH/STAGES segment and
// hands its carry, low sum bits and the remaining operand slices to the next stage.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int SEG = WIDTH / STAGES;
    localparam int GPS = SEG / CLA_GRP;

    logic [STAGES-1:0] vld_p;
    logic [STAGES-1:0] adv;

    // Inputs seen by stage k: the ports for stage 0, the stage k-1 registers otherwise.
    logic [WIDTH-1:0] src_a   [STAGES];
    logic [WIDTH-1:0] src_b   [STAGES];
    logic [WIDTH-1:0] src_sum [STAGES];
    logic             src_op  [STAGES];
    logic             src_cin [STAGES];
    logic             src_vld [STAGES];

    logic [WIDTH-1:0] a_p   [STAGES];
    logic [WIDTH-1:0] b_p   [STAGES];
    logic [WIDTH-1:0] sum_p [STAGES];
    logic             op_p  [STAGES];
    logic             cy_p  [STAGES];

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;

    assign src_a[0]   = in_a;
    assign src_b[0]   = in_b;
    assign src_sum[0] = '0;
    assign src_op[0]  = in_op;
    assign src_cin[0] = carry_in(in_op);
    assign src_vld[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEG;

        logic [SEG-1:0]   seg_a;
        logic [SEG-1:0]   seg_b;
        logic [SEG-1:0]   seg_sum;
        logic [GPS-1:0]   grp_g;
        logic [GPS-1:0]   grp_p;
        logic [GPS:0]     grp_c;
        logic [WIDTH-1:0] nxt_sum;

        // A stage may load when it is empty or everything downstream of it can drain.
        assign adv[k] = out_ready | ~(&vld_p[STAGES-1:k]);

        assign seg_a = src_a[k][LO +: SEG];
        assign seg_b = (src_op[k] == OP_ADD) ? src_b[k][LO +: SEG] : ~src_b[k][LO +: SEG];

        // Each group carry is a flat sum of products over the group G/P terms.
        always_comb begin
            logic acc;
            logic term;
            acc  = 1'b0;
            term = 1'b0;
            for (int j = 0; j <= GPS; j++) begin
                acc = src_cin[k];
                for (int i = 0; i < j; i++) acc = acc & grp_p[i];
                for (int i = 0; i < j; i++) begin
                    term = grp_g[i];
                    for (int m = i + 1; m < j; m++) term = term & grp_p[m];
                    acc = acc | term;
                end
                grp_c[j] = acc;
            end
        end

        for (genvar j = 0; j < GPS; j++) begin : g_grp
            cla_grp4 u_grp (
                .a   (seg_a[j*CLA_GRP +: CLA_GRP]),
                .b   (seg_b[j*CLA_GRP +: CLA_GRP]),
                .cin (grp_c[j]),
                .sum (seg_sum[j*CLA_GRP +: CLA_GRP]),
                .g   (grp_g[j]),
                .p   (grp_p[j])
            );
        end

        always_comb begin
            nxt_sum            = src_sum[k];
            nxt_sum[LO +: SEG] = seg_sum;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_p[k] <= 1'b0;
            end else if (adv[k]) begin
                vld_p[k] <= src_vld[k];
            end
        end

        if (k < STAGES - 1) begin : g_mid
            // ---- stage k -> stage k+1 boundary ----
            always_ff @(posedge clk) begin
                if (adv[k] && src_vld[k]) begin
                    a_p[k]   <= src_a[k];
                    b_p[k]   <= src_b[k];
                    op_p[k]  <= src_op[k];
                    cy_p[k]  <= grp_c[GPS];
                    sum_p[k] <= nxt_sum;
                end
            end

            assign src_a[k+1]   = a_p[k];
            assign src_b[k+1]   = b_p[k];
            assign src_sum[k+1] = sum_p[k];
            assign src_op[k+1]  = op_p[k];
            assign src_cin[k+1] = cy_p[k];
            assign src_vld[k+1] = vld_p[k];
        end else begin : g_last
            logic msb_cin;

            // Carry into the MSB recovered from that bit's sum and operands.
            assign msb_cin = seg_sum[SEG-1] ^ seg_a[SEG-1] ^ seg_b[SEG-1];

            // ---- last stage -> output register boundary ----
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q  <= '0;
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv[k] && src_vld[k]) begin
                    sum_q  <= nxt_sum;
                    cout_q <= grp_c[GPS];
                    ovf_q  <= msb_cin ^ grp_c[GPS];
                    zero_q <= ~|nxt_sum;
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_p[STAGES-1];
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Directed bench for cla_pipe_addsub: 16/2 vector table, streaming stall, reset, and width sweep.
module tb_cla_pipe_addsub;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance index: 0 = (16,2), 1 = (4,1), 2 = (32,4), 3 = (64,16)
    logic in_v  [4];
    logic rdy   [4];
    logic op    [4];
    logic out_v [4];
    logic out_r [4];
    logic cout  [4];
    logic ovf   [4];
    logic zero  [4];

    logic [15:0] a0, b0, s0;
    logic [3:0]  a1, b1, s1;
    logic [31:0] a2, b2, s2;
    logic [63:0] a3, b3, s3;

    cla_pipe_addsub #(.WIDTH(16), .STAGES(2)) u_w16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_v[0]), .in_ready(rdy[0]), .in_a(a0), .in_b(b0),
        .in_op(op[0]), .out_valid(out_v[0]), .out_ready(out_r[0]), .out_sum(s0),
        .out_cout(cout[0]), .out_ovf(ovf[0]), .out_zero(zero[0]));

    cla_pipe_addsub #(.WIDTH(4), .STAGES(1)) u_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_v[1]), .in_ready(rdy[1]), .in_a(a1), .in_b(b1),
        .in_op(op[1]), .out_valid(out_v[1]), .out_ready(out_r[1]), .out_sum(s1),
        .out_cout(cout[1]), .out_ovf(ovf[1]), .out_zero(zero[1]));

    cla_pipe_addsub #(.WIDTH(32), .STAGES(4)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_v[2]), .in_ready(rdy[2]), .in_a(a2), .in_b(b2),
        .in_op(op[2]), .out_valid(out_v[2]), .out_ready(out_r[2]), .out_sum(s2),
        .out_cout(cout[2]), .out_ovf(ovf[2]), .out_zero(zero[2]));

    cla_pipe_addsub #(.WIDTH(64), .STAGES(16)) u_w64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_v[3]), .in_ready(rdy[3]), .in_a(a3), .in_b(b3),
        .in_op(op[3]), .out_valid(out_v[3]), .out_ready(out_r[3]), .out_sum(s3),
        .out_cout(cout[3]), .out_ovf(ovf[3]), .out_zero(zero[3]));

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    int checks = 0;
    int errors = 0;

    vec_t        vecs [10];
    logic [15:0] st_a [8];
    logic [15:0] st_b [8];
    logic        st_op [8];
    logic [15:0] st_exp [8];

    logic [63:0] r_sum, e_sum, ta, tb_v, mask, held;
    logic        r_c, r_f, r_z, e_c, e_f, e_z, to, held_valid;
    int          lat, pushed, popped, occ, cyc, first_pop, w, stg;

    task automatic check_v(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int wid_of(input int i);
        case (i)
            0:       return 16;
            1:       return 4;
            2:       return 32;
            default: return 64;
        endcase
    endfunction

    function automatic int stg_of(input int i);
        case (i)
            0:       return 2;
            1:       return 1;
            2:       return 4;
            default: return 16;
        endcase
    endfunction

    task automatic drive(input int i, input logic vv, input logic [63:0] a, input logic [63:0] b,
                         input logic o);
        in_v[i] = vv;
        op[i]   = o;
        case (i)
            0:       begin a0 = a[15:0]; b0 = b[15:0]; end
            1:       begin a1 = a[3:0];  b1 = b[3:0];  end
            2:       begin a2 = a[31:0]; b2 = b[31:0]; end
            default: begin a3 = a;       b3 = b;       end
        endcase
    endtask

    function automatic logic [63:0] get_sum(input int i);
        case (i)
            0:       return {48'b0, s0};
            1:       return {60'b0, s1};
            2:       return {32'b0, s2};
            default: return s3;
        endcase
    endfunction

    // Independent reference: wide integer add, overflow from operand/result sign bits.
    task automatic model(input int wd, input logic [63:0] a, input logic [63:0] b, input logic o,
                         output logic [63:0] s, output logic c, output logic f, output logic z);
        logic [64:0] full;
        logic [63:0] m, bp, am;
        m    = (wd == 64) ? {64{1'b1}} : ((64'd1 << wd) - 64'd1);
        am   = a & m;
        bp   = (o ? ~b : b) & m;
        full = {1'b0, am} + {1'b0, bp} + {64'b0, o};
        s    = full[63:0] & m;
        c    = full[wd];
        f    = (am[wd-1] == bp[wd-1]) && (s[wd-1] != am[wd-1]);
        z    = (s == 64'b0);
    endtask

    task automatic single_op(input int i, input logic [63:0] a, input logic [63:0] b, input logic o,
                             output logic [63:0] s, output logic c, output logic f,
                             output logic z, output int l);
        @(negedge clk);
        drive(i, 1'b1, a, b, o);
        @(negedge clk);
        drive(i, 1'b0, 64'b0, 64'b0, 1'b0);
        l = 1;
        while (!out_v[i] && l < 40) begin
            @(negedge clk);
            l++;
        end
        s = get_sum(i);
        c = cout[i];
        f = ovf[i];
        z = zero[i];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};

        for (int k = 0; k < 8; k++) begin
            st_a[k]   = 16'h1000 + 16'(k) * 16'h0111;
            st_b[k]   = 16'(3 * k + 1);
            st_op[k]  = k[0];
            st_exp[k] = st_op[k] ? (st_a[k] - st_b[k]) : (st_a[k] + st_b[k]);
        end

        for (int i = 0; i < 4; i++) begin
            out_r[i] = 1'b1;
            drive(i, 1'b0, 64'b0, 64'b0, 1'b0);
        end

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_b("reset out_valid", out_v[0], 1'b0);
        check_v("reset out_sum", {48'b0, s0}, 64'h0);
        check_b("reset out_cout", cout[0], 1'b0);
        check_b("reset out_ovf", ovf[0], 1'b0);
        check_b("reset out_zero", zero[0], 1'b0);
        check_b("reset in_ready", rdy[0], 1'b1);

        // Directed vector table on the 16-bit, 2-stage instance
        for (int n = 0; n < 10; n++) begin
            single_op(0, {48'b0, vecs[n].a}, {48'b0, vecs[n].b}, vecs[n].op, r_sum, r_c, r_f, r_z, lat);
            check_v($sformatf("vec%0d sum", n), r_sum, {48'b0, vecs[n].sum});
            check_b($sformatf("vec%0d cout", n), r_c, vecs[n].cout);
            check_b($sformatf("vec%0d ovf", n), r_f, vecs[n].ovf);
            check_b($sformatf("vec%0d zero", n), r_z, vecs[n].zero);
            check_i($sformatf("vec%0d latency", n), lat, 2);
        end

        // Streaming with a 3-cycle output stall mid-stream
        @(negedge clk);
        pushed = 0; popped = 0; cyc = 0; first_pop = -1; held_valid = 1'b0; held = '0;
        while (popped < 8 && cyc < 60) begin
            if (cyc > 0) @(negedge clk);
            out_r[0] = !(cyc >= 4 && cyc < 7);
            occ = pushed - popped;
            if (pushed < 8) drive(0, 1'b1, {48'b0, st_a[pushed]}, {48'b0, st_b[pushed]}, st_op[pushed]);
            else            drive(0, 1'b0, 64'b0, 64'b0, 1'b0);
            #1;
            check_b($sformatf("stream in_ready c%0d", cyc), rdy[0], (occ < 2) || out_r[0]);
            if (!rdy[0] && in_v[0]) a0 = 16'hDEAD;
            if (held_valid) check_v($sformatf("stall hold c%0d", cyc), {48'b0, s0}, held);
            if (out_v[0] && out_r[0]) begin
                if (first_pop < 0) first_pop = cyc;
                check_v($sformatf("stream result %0d", popped), {48'b0, s0}, {48'b0, st_exp[popped]});
                popped++;
            end
            held_valid = out_v[0] && !out_r[0];
            held       = {48'b0, s0};
            if (in_v[0] && rdy[0]) pushed++;
            cyc++;
        end
        drive(0, 1'b0, 64'b0, 64'b0, 1'b0);
        out_r[0] = 1'b1;
        check_i("stream first latency", first_pop, 2);
        check_i("stream pushed", pushed, 8);
        check_i("stream popped", popped, 8);
        @(negedge clk);
        #1;
        check_b("stream drained", out_v[0], 1'b0);

        // Reset with two operations in flight
        out_r[0] = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, 64'h1234, 64'h1111, 1'b0);
        @(negedge clk);
        drive(0, 1'b1, 64'h4000, 64'h0001, 1'b1);
        @(negedge clk);
        drive(0, 1'b0, 64'b0, 64'b0, 1'b0);
        #1;
        check_b("pre-reset out_valid", out_v[0], 1'b1);
        check_v("pre-reset out_sum", {48'b0, s0}, 64'h2345);
        rst_n = 1'b0;
        #1;
        check_b("mid-reset out_valid", out_v[0], 1'b0);
        check_v("mid-reset out_sum", {48'b0, s0}, 64'h0);
        check_b("mid-reset out_cout", cout[0], 1'b0);
        check_b("mid-reset out_ovf", ovf[0], 1'b0);
        check_b("mid-reset out_zero", zero[0], 1'b0);
        @(negedge clk);
        rst_n    = 1'b1;
        out_r[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check_b($sformatf("post-reset stale valid %0d", k), out_v[0], 1'b0);
        end
        single_op(0, 64'h0010, 64'h0020, 1'b0, r_sum, r_c, r_f, r_z, lat);
        check_v("post-reset sum", r_sum, 64'h0030);
        check_i("post-reset latency", lat, 2);

        // Width/stage sweep against the reference model
        for (int i = 1; i < 4; i++) begin
            w    = wid_of(i);
            stg  = stg_of(i);
            mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
            for (int n = 0; n < 8; n++) begin
                if (n == 0) begin
                    ta = mask; tb_v = 64'd1; to = 1'b0;
                end else if (n == 1) begin
                    ta = 64'd1 << (w - 1); tb_v = 64'd1; to = 1'b1;
                end else begin
                    ta   = {$urandom, $urandom} & mask;
                    tb_v = {$urandom, $urandom} & mask;
                    to   = 1'($urandom_range(0, 1));
                end
                model(w, ta, tb_v, to, e_sum, e_c, e_f, e_z);
                single_op(i, ta, tb_v, to, r_sum, r_c, r_f, r_z, lat);
                check_v($sformatf("w%0d op%0d sum", w, n), r_sum, e_sum);
                check_b($sformatf("w%0d op%0d cout", w, n), r_c, e_c);
                check_b($sformatf("w%0d op%0d ovf", w, n), r_f, e_f);
                check_b($sformatf("w%0d op%0d zero", w, n), r_z, e_z);
                check_i($sformatf("w%0d op%0d latency", w, n), lat, stg);
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
